// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DIV_WIDTH      default operand width
//   state_t        FSM state type, with ST_IDLE / ST_RUN / ST_DONE encodings
//   DIV0_QUOTIENT  quotient reported for a zero divisor (all ones)
package div_pkg;

   localparam int DIV_WIDTH = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   rem_in   partial remainder before this step (WIDTH+1 bits)
//   bit_in   next dividend bit, shifted into the remainder LSB
//   divisor  unsigned divisor
//   rem_out  partial remainder after the trial subtract / restore
//   q_bit    quotient bit produced by this step (1 = subtract kept)
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   // One extra bit of headroom so the borrow of the trial subtraction is
   // always the MSB, whatever the incoming partial remainder holds.
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   assign shifted = {rem_in, bit_in};
   assign diff    = shifted - {2'b00, divisor};
   assign q_bit   = ~diff[WIDTH+1];
   assign rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider, one quotient bit per clock (restoring).
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        begin a division; only honoured while ready=1
//   dividend     unsigned dividend, captured on the accepted start edge
//   divisor      unsigned divisor, captured on the accepted start edge
//   ready        high in IDLE and DONE
//   done         one-cycle pulse; results valid from this cycle on
//   quotient     result quotient, held until the next result
//   remainder    result remainder, held until the next result
//   div_by_zero  result flag for a zero divisor, held with the results
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [WIDTH-1:0] DIV0_Q =
      (WIDTH == DIV_WIDTH) ? DIV0_QUOTIENT : {WIDTH{1'b1}};

   state_t           state_reg,     state_next;
   logic [CW-1:0]    counter_reg,   counter_next;
   logic [WIDTH:0]   prem_reg,      prem_next;
   logic [WIDTH-1:0] qsh_reg,       qsh_next;
   logic [WIDTH-1:0] dvsr_reg,      dvsr_next;
   logic [WIDTH-1:0] quotient_reg,  quotient_next;
   logic [WIDTH-1:0] remainder_reg, remainder_next;
   logic             dz_reg,        dz_next;

   logic [WIDTH:0]   step_rem;
   logic             step_q;

   // The quotient shift register starts out holding the dividend: its MSB
   // feeds the remainder each step while the new quotient bit enters at LSB.
   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_in  (prem_reg),
      .bit_in  (qsh_reg[WIDTH-1]),
      .divisor (dvsr_reg),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   always_comb begin
      state_next     = state_reg;
      counter_next   = counter_reg;
      prem_next      = prem_reg;
      qsh_next       = qsh_reg;
      dvsr_next      = dvsr_reg;
      quotient_next  = quotient_reg;
      remainder_next = remainder_reg;
      dz_next        = dz_reg;

      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               dvsr_next = divisor;
               if (divisor == '0) begin
                  // No iterations needed: the result is known immediately.
                  quotient_next  = DIV0_Q;
                  remainder_next = dividend;
                  dz_next        = 1'b1;
                  state_next     = ST_DONE;
               end else begin
                  prem_next    = '0;
                  qsh_next     = dividend;
                  counter_next = CW'(WIDTH);
                  state_next   = ST_RUN;
               end
            end else if (state_reg == ST_DONE) begin
               state_next = ST_IDLE;
            end
         end

         ST_RUN: begin
            prem_next    = step_rem;
            qsh_next     = {qsh_reg[WIDTH-2:0], step_q};
            counter_next = counter_reg - CW'(1);
            if (counter_reg == CW'(1)) begin
               // Last iteration: publish the step outputs directly.
               quotient_next  = {qsh_reg[WIDTH-2:0], step_q};
               remainder_next = step_rem[WIDTH-1:0];
               dz_next        = 1'b0;
               state_next     = ST_DONE;
            end
         end

         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         counter_reg   <= '0;
         prem_reg      <= '0;
         qsh_reg       <= '0;
         dvsr_reg      <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dz_reg        <= 1'b0;
      end else begin
         state_reg     <= state_next;
         counter_reg   <= counter_next;
         prem_reg      <= prem_next;
         qsh_reg       <= qsh_next;
         dvsr_reg      <= dvsr_next;
         quotient_reg  <= quotient_next;
         remainder_reg <= remainder_next;
         dz_reg        <= dz_next;
      end
   end

   assign ready       = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
   assign done        = (state_reg == ST_DONE);
   assign quotient    = quotient_reg;
   assign remainder   = remainder_reg;
   assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus randomized
// operands checked against plain integer division.
module tb_seq_divider;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         ready;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_vec  = 0;
   int n_fail = 0;
   bit ready_err;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Reference: plain unsigned arithmetic, zero divisor reported as all ones.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic dz);
      if (b == 0) begin
         q  = {W{1'b1}};
         r  = a;
         dz = 1'b1;
      end else begin
         q  = a / b;
         r  = a % b;
         dz = 1'b0;
      end
   endfunction

   // Drive one start; returns 1 cycle after the accepting edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
      ready_err = 1'b0;
      start     = 1'b1;
      dividend  = a;
      divisor   = b;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
   endtask

   // Count edges (accept edge = 1) until done is seen; -1 on timeout.
   // Any cycle before done with ready high is recorded in ready_err.
   task automatic wait_done(input int lat0, output int lat);
      lat = lat0;
      while (done !== 1'b1 && lat < 100) begin
         if (ready !== 1'b0) ready_err = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      if (done !== 1'b1) lat = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({ready, done, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'd0, 16'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: ready=%0b done=%0b q=%0d r=%0d dz=%0b, want 1 0 0 0 0",
                  ready, done, quotient, remainder, div_by_zero);
      end
      rst = 1'b0;
      $display("reset: ready=%0b done=%0b q=%0d r=%0d dz=%0b", ready, done, quotient, remainder, div_by_zero);
   endtask

   task automatic test_max_by_one();
      int lat;
      issue(16'd65535, 16'd1, 1'b0);
      wait_done(1, lat);
      n_vec++;
      if (lat !== 17) begin n_fail++; $display("FAIL max_by_one latency: got %0d want 17", lat); end
      n_vec++;
      if ({quotient, remainder, div_by_zero} !== {16'd65535, 16'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL max_by_one result: q=%0d r=%0d dz=%0b want 65535 0 0", quotient, remainder, div_by_zero);
      end
      n_vec++;
      if (ready_err) begin n_fail++; $display("FAIL max_by_one ready: got 1 in RUN want 0"); end
      $display("max_by_one: 65535/1 -> q=%0d r=%0d dz=%0b lat=%0d", quotient, remainder, div_by_zero, lat);
   endtask

   task automatic test_back_to_back();
      int lat;
      issue(16'd65535, 16'd65535, 1'b0);
      wait_done(1, lat);
      n_vec++;
      if ({quotient, remainder, div_by_zero} !== {16'd1, 16'd0, 1'b0} || lat !== 17) begin
         n_fail++;
         $display("FAIL b2b first: q=%0d r=%0d dz=%0b lat=%0d want 1 0 0 17", quotient, remainder, div_by_zero, lat);
      end
      $display("b2b first: 65535/65535 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
      // Start is raised while the first done is still high.
      issue(16'd219, 16'd102, 1'b0);
      n_vec++;
      if ({done, ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b accept: done=%0b ready=%0b want 0 0", done, ready);
      end
      wait_done(1, lat);
      n_vec++;
      if (lat !== 17) begin n_fail++; $display("FAIL b2b spacing: got %0d want 17", lat); end
      n_vec++;
      if ({quotient, remainder, div_by_zero} !== {16'd2, 16'd15, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b second: q=%0d r=%0d dz=%0b want 2 15 0", quotient, remainder, div_by_zero);
      end
      $display("b2b second: 219/102 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
   endtask

   task automatic test_div_zero();
      int lat;
      issue(16'd100, 16'd0, 1'b0);
      wait_done(1, lat);
      n_vec++;
      if (lat !== 1) begin n_fail++; $display("FAIL div_zero latency: got %0d want 1", lat); end
      n_vec++;
      if ({quotient, remainder, div_by_zero} !== {16'd65535, 16'd100, 1'b1}) begin
         n_fail++;
         $display("FAIL div_zero result: q=%0d r=%0d dz=%0b want 65535 100 1", quotient, remainder, div_by_zero);
      end
      $display("div_zero: 100/0 -> q=%0d r=%0d dz=%0b lat=%0d", quotient, remainder, div_by_zero, lat);
      @(posedge clk); #1;
      n_vec++;
      if ({done, ready, div_by_zero} !== 3'b011) begin
         n_fail++;
         $display("FAIL div_zero pulse: done=%0b ready=%0b dz=%0b want 0 1 1", done, ready, div_by_zero);
      end
      issue(16'd7, 16'd3, 1'b0);
      wait_done(1, lat);
      n_vec++;
      if ({quotient, remainder, div_by_zero} !== {16'd2, 16'd1, 1'b0} || lat !== 17) begin
         n_fail++;
         $display("FAIL div_zero clear: q=%0d r=%0d dz=%0b lat=%0d want 2 1 0 17", quotient, remainder, div_by_zero, lat);
      end
      $display("div_zero clear: 7/3 -> q=%0d r=%0d dz=%0b lat=%0d", quotient, remainder, div_by_zero, lat);
   endtask

   task automatic test_start_in_run();
      int lat;
      issue(16'd1000, 16'd7, 1'b0);
      repeat (3) begin
         if (ready !== 1'b0) ready_err = 1'b1;
         @(posedge clk); #1;
      end
      // RUN cycle 4: a competing start with different operands.
      start    = 1'b1;
      dividend = 16'd5;
      divisor  = 16'd5;
      if (ready !== 1'b0) ready_err = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(5, lat);
      n_vec++;
      if (lat !== 17) begin n_fail++; $display("FAIL start_in_run latency: got %0d want 17", lat); end
      n_vec++;
      if ({quotient, remainder, div_by_zero} !== {16'd142, 16'd6, 1'b0}) begin
         n_fail++;
         $display("FAIL start_in_run result: q=%0d r=%0d dz=%0b want 142 6 0", quotient, remainder, div_by_zero);
      end
      n_vec++;
      if (ready_err) begin n_fail++; $display("FAIL start_in_run ready: got 1 in RUN want 0"); end
      $display("start_in_run: 1000/7 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
   endtask

   task automatic test_reset_mid_run();
      int lat;
      int seen;
      issue(16'd50000, 16'd3, 1'b0);
      repeat (7) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++;
      if ({ready, done, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'd0, 16'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid_run state: ready=%0b done=%0b q=%0d r=%0d dz=%0b want 1 0 0 0 0",
                  ready, done, quotient, remainder, div_by_zero);
      end
      seen = 0;
      repeat (25) begin
         if (done === 1'b1) seen++;
         @(posedge clk); #1;
      end
      n_vec++;
      if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_run done pulses: got %0d want 0", seen); end
      $display("reset_mid_run: 50000/3 aborted, done pulses=%0d", seen);
      issue(16'd9, 16'd4, 1'b0);
      wait_done(1, lat);
      n_vec++;
      if ({quotient, remainder, div_by_zero} !== {16'd2, 16'd1, 1'b0} || lat !== 17) begin
         n_fail++;
         $display("FAIL reset_mid_run fresh: q=%0d r=%0d dz=%0b lat=%0d want 2 1 0 17", quotient, remainder, div_by_zero, lat);
      end
      $display("reset_mid_run fresh: 9/4 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
   endtask

   task automatic test_small();
      int lat;
      issue(16'd3, 16'd5, 1'b0);
      wait_done(1, lat);
      n_vec++;
      if ({quotient, remainder, div_by_zero} !== {16'd0, 16'd3, 1'b0} || lat !== 17) begin
         n_fail++;
         $display("FAIL small 3/5: q=%0d r=%0d dz=%0b lat=%0d want 0 3 0 17", quotient, remainder, div_by_zero, lat);
      end
      $display("small: 3/5 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
      issue(16'd0, 16'd9, 1'b0);
      wait_done(1, lat);
      n_vec++;
      if ({quotient, remainder, div_by_zero} !== {16'd0, 16'd0, 1'b0} || lat !== 17) begin
         n_fail++;
         $display("FAIL small 0/9: q=%0d r=%0d dz=%0b lat=%0d want 0 0 0 17", quotient, remainder, div_by_zero, lat);
      end
      $display("small: 0/9 -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, eq, er;
      logic         edz;
      int           lat, elat, sel;
      for (int i = 0; i < 60; i++) begin
         a   = W'($urandom);
         sel = int'($urandom_range(0, 7));
         if (sel == 0)      b = '0;
         else if (sel <= 2) b = W'($urandom_range(1, 15));
         else if (sel == 3) b = a;
         else               b = W'($urandom);
         model(a, b, eq, er, edz);
         elat = (b == 0) ? 1 : 17;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         issue(a, b, 1'b0);
         wait_done(1, lat);
         n_vec++;
         if ({quotient, remainder, div_by_zero} !== {eq, er, edz} || lat !== elat) begin
            n_fail++;
            $display("FAIL random %0d/%0d: q=%0d r=%0d dz=%0b lat=%0d want %0d %0d %0b %0d",
                     a, b, quotient, remainder, div_by_zero, lat, eq, er, edz, elat);
         end
         $display("random %0d: %0d/%0d -> q=%0d r=%0d dz=%0b lat=%0d", i, a, b, quotient, remainder, div_by_zero, lat);
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      test_reset();
      test_max_by_one();
      test_back_to_back();
      test_div_zero();
      test_start_in_run();
      test_reset_mid_run();
      test_small();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned integer divider, one quotient bit per clock (restoring algorithm).
- Inverse-operation companion to the 16x16 Wallace multiplier; together they form the integer MUL/DIV functional units behind the scoreboard.
- Uses a start/done handshake so the scoreboard can issue to it and track it as a long-latency unit.

Parameters:
- WIDTH, 16, operand width in bits; dividend, divisor, quotient and remainder are all WIDTH bits.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a division; sampled only when ready=1.
- dividend  input  WIDTH  unsigned dividend; captured on the accepted start edge.
- divisor  input  WIDTH  unsigned divisor; captured on the accepted start edge.
- ready  output  1  high in IDLE and DONE; start is accepted only when ready=1.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  output  WIDTH  result quotient; held until the next accepted start.
- remainder  output  WIDTH  result remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when the captured divisor was 0; held with the results.

Behaviour:
- Reset values: ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE, counter=0.
- States:
  - IDLE: ready=1.
  - RUN: ready=0.
  - DONE: ready=1, done=1.
- IDLE or DONE, start=1 at edge E:
  - Capture the operands. Load the partial remainder (WIDTH+1 bits) with 0 and the quotient shift register with the dividend. Set counter=WIDTH. Go to RUN.
  - If the divisor is 0, go directly to DONE at edge E instead: quotient=all ones, remainder=dividend, div_by_zero=1. done is then high in the cycle after E.
- DONE, start=0: go to IDLE at the next edge. done is high for exactly one cycle.
- RUN, each edge:
  - Shift {partial remainder, quotient} left by 1.
  - Trial subtract the divisor. If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set the LSB to 0.
  - Decrement counter. On the edge where counter reaches 0, go to DONE and register the final quotient and remainder.
- Latency:
  - Start accepted at edge E, divisor non-zero: done is high in the cycle following edge E+WIDTH. That is WIDTH+1 edges, or 17 cycles for WIDTH=16.
  - Divisor zero: 1 cycle.
- start in RUN: ignored with no side effects. Inputs are not re-sampled; operands are only read at the accept edge.
- Back-to-back: start=1 in DONE is accepted. The new operation begins and done drops at the next edge.
- Outputs quotient, remainder and div_by_zero change only at a DONE entry. div_by_zero clears at the next DONE entry with a non-zero divisor.
- rst=1 in any state, including mid-RUN: at the next edge, return to reset values. Any in-flight result is discarded and no done pulse is produced.
- Arithmetic: fully unsigned. The partial remainder is WIDTH+1 bits so the subtraction borrow is its MSB. No overflow case exists for a non-zero divisor.

Decomposition:
- Shared package `div_pkg`:
  - DIV_WIDTH constant (16).
  - state typedef with IDLE, RUN and DONE encodings.
  - DIV0_QUOTIENT constant (all ones).
- One natural sub-module, `div_step`: purely combinational single restoring iteration.
  - Inputs: partial remainder, the next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once inside seq_divider; the FSM and registers stay in the top.

Test Plan:
- 65535 / 1 -> done at 17th edge after start, quotient=65535, remainder=0, div_by_zero=0.
- 65535 / 65535 -> quotient=1, remainder=0. Then 219 / 102 back-to-back, start held high in DONE -> quotient=2, remainder=15, second done exactly 17 cycles after the first.
- 100 / 0 -> done in the cycle after the start edge, quotient=65535, remainder=100, div_by_zero=1. Then 7 / 3 -> quotient=2, remainder=1, div_by_zero=0.
- Start 1000 / 7, then pulse start with 5 / 5 at RUN cycle 4 -> second start ignored; result quotient=142, remainder=6, ready=0 throughout RUN.
- Start 50000 / 3, assert rst at RUN cycle 8 -> next edge: all outputs 0, ready=1, no done pulse. A fresh 9 / 4 then yields quotient=2, remainder=1.
- 3 / 5 (dividend < divisor) -> quotient=0, remainder=3; 0 / 9 -> quotient=0, remainder=0.
